// File: rtl/qbert_move_ctrl.sv
// Q*bert movement controller: accepts jump requests, walks a one-hot
// position over a triangular pyramid, times the jump animation, colours
// landing cubes and handles falls, level completion and level clear.
module qbert_move_ctrl #(
  parameter int N_cube      = 28,
  parameter int ROWS        = 7,
  parameter int MOVE_CYCLES = 16,
  parameter int FALL_CYCLES = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              jump_valid,
  input  logic [2:0]        e_jump_qb,
  output logic              jump_ready,
  input  logic              clear_lvl,
  output logic [N_cube-1:0] position_qb,
  output logic [N_cube-1:0] e_next_qb,
  output logic [N_cube-1:0] e_color_state,
  output logic              done_move,
  output logic              falling,
  output logic              level_done
);

  localparam int MAX_CYC = (MOVE_CYCLES > FALL_CYCLES) ? MOVE_CYCLES : FALL_CYCLES;
  localparam int CW      = $clog2(MAX_CYC) + 1;
  localparam int RW      = $clog2(ROWS) + 1;
  localparam logic [CW-1:0]     MOVE_LAST = CW'(MOVE_CYCLES - 1);
  localparam logic [CW-1:0]     FALL_LAST = CW'(FALL_CYCLES - 1);
  localparam logic [N_cube-1:0] CUBE0     = N_cube'(1);

  // Geometry and timing sanity: a mismatched cube count would make the
  // one-hot index math address cubes that do not exist.
  generate
    if (N_cube != ROWS * (ROWS + 1) / 2) begin : g_bad_geometry
      $error("qbert_move_ctrl: N_cube must equal ROWS*(ROWS+1)/2");
    end
    if (MOVE_CYCLES < 1 || FALL_CYCLES < 1) begin : g_bad_timing
      $error("qbert_move_ctrl: MOVE_CYCLES and FALL_CYCLES must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_LAND, S_FALL} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [RW-1:0]     row_reg, row_next, col_reg, col_next;
  logic [RW-1:0]     dst_row_reg, dst_row_next, dst_col_reg, dst_col_next;
  logic [N_cube-1:0] pos_reg, pos_next, enext_reg, enext_next;
  logic [N_cube-1:0] color_reg, color_next;
  logic              done_reg, done_next, falling_reg, falling_next;
  logic              level_reg, level_next, ready_reg, ready_next;

  int                dst_r, dst_c, dest_idx;
  logic              dir_valid, dest_on;
  logic [N_cube-1:0] dest_onehot;

  // Destination row/col for the requested direction and whether it lies on the pyramid.
  always_comb begin
    dst_r     = int'(row_reg);
    dst_c     = int'(col_reg);
    dir_valid = 1'b1;
    case (e_jump_qb)
      3'd1:    dst_r = int'(row_reg) - 1;
      3'd2:    begin dst_r = int'(row_reg) - 1; dst_c = int'(col_reg) - 1; end
      3'd3:    begin dst_r = int'(row_reg) + 1; dst_c = int'(col_reg) + 1; end
      3'd4:    dst_r = int'(row_reg) + 1;
      default: dir_valid = 1'b0;
    endcase
    dest_on  = (dst_r >= 0) && (dst_r <= ROWS - 1) && (dst_c >= 0) && (dst_c <= dst_r);
    dest_idx = dst_r * (dst_r + 1) / 2 + dst_c;
  end

  generate
    for (genvar gi = 0; gi < N_cube; gi++) begin : g_onehot
      assign dest_onehot[gi] = (dest_idx == gi);
    end
  endgenerate

  // Next-state and registered-output logic; clear_lvl overrides everything.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    row_next     = row_reg;
    col_next     = col_reg;
    dst_row_next = dst_row_reg;
    dst_col_next = dst_col_reg;
    pos_next     = pos_reg;
    enext_next   = enext_reg;
    color_next   = color_reg;
    done_next    = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (jump_valid && ready_reg && dir_valid) begin
          cnt_next = '0;
          if (dest_on) begin
            enext_next   = dest_onehot;
            dst_row_next = dst_r[RW-1:0];
            dst_col_next = dst_c[RW-1:0];
            state_next   = S_MOVE;
          end else begin
            state_next = S_FALL;
          end
        end
      end
      S_MOVE: begin
        if (cnt_reg == MOVE_LAST) state_next = S_LAND;
        else                      cnt_next   = cnt_reg + CW'(1);
      end
      S_LAND: begin
        pos_next   = enext_reg;
        row_next   = dst_row_reg;
        col_next   = dst_col_reg;
        color_next = color_reg | enext_reg;
        done_next  = 1'b1;
        state_next = S_IDLE;
      end
      S_FALL: begin
        if (cnt_reg == FALL_LAST) begin
          pos_next   = CUBE0;
          enext_next = CUBE0;
          row_next   = '0;
          col_next   = '0;
          cnt_next   = '0;
          done_next  = 1'b1;
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase

    if (clear_lvl) begin
      state_next = S_IDLE;
      cnt_next   = '0;
      row_next   = '0;
      col_next   = '0;
      pos_next   = CUBE0;
      enext_next = CUBE0;
      color_next = '0;
      done_next  = 1'b1;
    end

    // Flags are derived from the next state so they line up with the data they describe.
    falling_next = (state_next == S_FALL);
    level_next   = &color_next;
    ready_next   = (state_next == S_IDLE) && !level_next;
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      row_reg     <= '0;
      col_reg     <= '0;
      dst_row_reg <= '0;
      dst_col_reg <= '0;
      pos_reg     <= CUBE0;
      enext_reg   <= CUBE0;
      color_reg   <= '0;
      done_reg    <= 1'b0;
      falling_reg <= 1'b0;
      level_reg   <= 1'b0;
      ready_reg   <= 1'b1;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      row_reg     <= row_next;
      col_reg     <= col_next;
      dst_row_reg <= dst_row_next;
      dst_col_reg <= dst_col_next;
      pos_reg     <= pos_next;
      enext_reg   <= enext_next;
      color_reg   <= color_next;
      done_reg    <= done_next;
      falling_reg <= falling_next;
      level_reg   <= level_next;
      ready_reg   <= ready_next;
    end
  end

  assign position_qb   = pos_reg;
  assign e_next_qb     = enext_reg;
  assign e_color_state = color_reg;
  assign done_move     = done_reg;
  assign falling       = falling_reg;
  assign level_done    = level_reg;
  assign jump_ready    = ready_reg;

endmodule

// File: tb/tb_qbert_move_ctrl.sv
// Directed bench for qbert_move_ctrl: a table of jumps walking the whole
// pyramid plus hand-written sequences for timing and clear/reset corners.
module tb_qbert_move_ctrl;

  localparam int N_cube      = 28;
  localparam int ROWS        = 7;
  localparam int MOVE_CYCLES = 16;
  localparam int FALL_CYCLES = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              jump_valid;
  logic [2:0]        e_jump_qb;
  logic              jump_ready;
  logic              clear_lvl;
  logic [N_cube-1:0] position_qb;
  logic [N_cube-1:0] e_next_qb;
  logic [N_cube-1:0] e_color_state;
  logic              done_move;
  logic              falling;
  logic              level_done;

  qbert_move_ctrl #(
    .N_cube(N_cube), .ROWS(ROWS), .MOVE_CYCLES(MOVE_CYCLES), .FALL_CYCLES(FALL_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .jump_valid(jump_valid), .e_jump_qb(e_jump_qb),
    .jump_ready(jump_ready), .clear_lvl(clear_lvl), .position_qb(position_qb),
    .e_next_qb(e_next_qb), .e_color_state(e_color_state), .done_move(done_move),
    .falling(falling), .level_done(level_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] dir;
    bit         fall;
    int         idx;
  } vec_t;

  vec_t              vq[$];
  int                checks = 0;
  int                errors = 0;
  logic [N_cube-1:0] color_model;
  logic [N_cube-1:0] pos_model;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] dir, input bit fall, input int idx);
    vec_t v;
    v.dir  = dir;
    v.fall = fall;
    v.idx  = idx;
    vq.push_back(v);
  endtask

  // One complete jump: request, check destination, wait for done_move, check result.
  task automatic do_jump(input logic [2:0] dir, input bit fall, input int idx);
    logic [N_cube-1:0] exp_dst;
    int k;
    int lat_exp;
    bit fall_err;
    exp_dst = fall ? N_cube'(1) : (N_cube'(1) << idx);
    k = 0;
    while (jump_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    chk("ready_before_jump", jump_ready, 1);
    jump_valid = 1'b1; e_jump_qb = dir;
    @(negedge clk);
    jump_valid = 1'b0; e_jump_qb = 3'd0;
    chk("next_after_accept", e_next_qb, fall ? pos_model : exp_dst);
    lat_exp  = fall ? FALL_CYCLES + 1 : MOVE_CYCLES + 2;
    k        = 1;
    fall_err = 1'b0;
    while (done_move !== 1'b1 && k < 100) begin
      if (falling !== fall) fall_err = 1'b1;
      @(negedge clk);
      k++;
    end
    if (!fall) color_model = color_model | exp_dst;
    pos_model = exp_dst;
    chk("falling_during_jump", fall_err, 0);
    chk("done_latency", k, lat_exp);
    chk("position_at_done", position_qb, exp_dst);
    chk("next_at_done", e_next_qb, exp_dst);
    chk("color_at_done", e_color_state, color_model);
    chk("falling_at_done", falling, 0);
    $display("jump dir=%0d fall=%0d -> pos=%h color=%h latency=%0d",
             dir, fall, position_qb, e_color_state, k);
    @(negedge clk);
    chk("done_single_pulse", done_move, 0);
  endtask

  initial begin
    int k;
    int dones;
    reset = 1'b0; jump_valid = 1'b0; e_jump_qb = 3'd0; clear_lvl = 1'b0;
    color_model = '0;
    pos_model   = N_cube'(1);

    // T1: reset values
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_position", position_qb, 28'h1);
    chk("rst_next", e_next_qb, 28'h1);
    chk("rst_color", e_color_state, 0);
    chk("rst_done", done_move, 0);
    chk("rst_falling", falling, 0);
    chk("rst_level_done", level_done, 0);
    chk("rst_jump_ready", jump_ready, 1);
    $display("reset released: pos=%h ready=%0d", position_qb, jump_ready);

    // T2: down-right from the apex lands on cube 2 (28'h4)
    do_jump(3'd3, 1'b0, 2);
    // Back to the apex, then T3: up-left off the top falls, colours kept
    do_jump(3'd2, 1'b0, 0);
    do_jump(3'd2, 1'b1, 0);

    // Invalid direction codes are consumed with no effect
    jump_valid = 1'b1; e_jump_qb = 3'd0;
    @(negedge clk);
    e_jump_qb = 3'd7;
    @(negedge clk);
    jump_valid = 1'b0; e_jump_qb = 3'd0;
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      if (done_move === 1'b1 || falling === 1'b1) dones++;
      @(negedge clk);
    end
    chk("invalid_no_activity", dones, 0);
    chk("invalid_position", position_qb, pos_model);
    chk("invalid_next", e_next_qb, pos_model);
    chk("invalid_ready", jump_ready, 1);
    $display("invalid codes 0,7: pos=%h ready=%0d", position_qb, jump_ready);

    // T4: a second request during MOVE is ignored
    jump_valid = 1'b1; e_jump_qb = 3'd4;
    @(negedge clk);
    jump_valid = 1'b0; e_jump_qb = 3'd0;
    dones = 0;
    for (int i = 1; i <= 60; i++) begin
      if (done_move === 1'b1) dones++;
      jump_valid = (i == 5);
      e_jump_qb  = (i == 5) ? 3'd3 : 3'd0;
      @(negedge clk);
    end
    color_model = color_model | 28'h2;
    pos_model   = 28'h2;
    chk("t4_done_count", dones, 1);
    chk("t4_position", position_qb, 28'h2);
    chk("t4_next", e_next_qb, 28'h2);
    chk("t4_color", e_color_state, color_model);
    $display("double request: dones=%0d pos=%h", dones, position_qb);

    // T6: clear_lvl at MOVE count 5 aborts the move without colouring
    jump_valid = 1'b1; e_jump_qb = 3'd3;
    @(negedge clk);
    jump_valid = 1'b0; e_jump_qb = 3'd0;
    repeat (5) @(negedge clk);
    clear_lvl = 1'b1;
    @(negedge clk);
    clear_lvl = 1'b0;
    chk("t6_position", position_qb, 28'h1);
    chk("t6_next", e_next_qb, 28'h1);
    chk("t6_color", e_color_state, 0);
    chk("t6_done", done_move, 1);
    chk("t6_falling", falling, 0);
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done_move === 1'b1) dones++;
    end
    chk("t6_no_land", dones, 0);
    chk("t6_color_kept_clear", e_color_state, 0);
    chk("t6_position_kept", position_qb, 28'h1);
    $display("clear mid-move: pos=%h color=%h late_dones=%0d", position_qb, e_color_state, dones);
    color_model = '0;
    pos_model   = 28'h1;

    // T5: table walk - boundary falls, then a path visiting all 28 cubes
    add(3'd1, 1, 0);  add(3'd2, 1, 0);
    add(3'd4, 0, 1);  add(3'd4, 0, 3);  add(3'd4, 0, 6);
    add(3'd4, 0, 10); add(3'd4, 0, 15); add(3'd4, 0, 21);
    add(3'd4, 1, 0);
    add(3'd4, 0, 1);  add(3'd1, 0, 0);  add(3'd4, 0, 1);  add(3'd4, 0, 3);
    add(3'd4, 0, 6);  add(3'd4, 0, 10); add(3'd4, 0, 15); add(3'd4, 0, 21);
    add(3'd1, 0, 15); add(3'd3, 0, 22); add(3'd1, 0, 16); add(3'd1, 0, 11);
    add(3'd1, 0, 7);  add(3'd1, 0, 4);  add(3'd1, 0, 2);  add(3'd3, 0, 5);
    add(3'd4, 0, 8);  add(3'd4, 0, 12); add(3'd4, 0, 17); add(3'd4, 0, 23);
    add(3'd1, 0, 17); add(3'd3, 0, 24); add(3'd1, 0, 18); add(3'd1, 0, 13);
    add(3'd1, 0, 9);  add(3'd3, 0, 14); add(3'd4, 0, 19); add(3'd4, 0, 25);
    add(3'd1, 0, 19); add(3'd3, 0, 26); add(3'd1, 0, 20); add(3'd3, 0, 27);
    foreach (vq[i]) begin
      if (i < $size(vq) - 1) chk("level_done_early", level_done, 0);
      do_jump(vq[i].dir, vq[i].fall, vq[i].idx);
    end
    @(negedge clk);
    chk("t5_all_colored", e_color_state, 28'hFFFFFFF);
    chk("t5_level_done", level_done, 1);
    chk("t5_ready_low", jump_ready, 0);
    jump_valid = 1'b1; e_jump_qb = 3'd2;
    @(negedge clk);
    jump_valid = 1'b0; e_jump_qb = 3'd0;
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      if (done_move === 1'b1) dones++;
      @(negedge clk);
    end
    chk("t5_blocked_jump", dones, 0);
    chk("t5_position_held", position_qb, 28'h8000000);
    clear_lvl = 1'b1;
    @(negedge clk);
    clear_lvl = 1'b0;
    chk("t5_clear_color", e_color_state, 0);
    chk("t5_clear_done", done_move, 1);
    chk("t5_clear_position", position_qb, 28'h1);
    @(negedge clk);
    chk("t5_clear_level_done", level_done, 0);
    chk("t5_clear_ready", jump_ready, 1);
    $display("level clear: color=%h level_done=%0d ready=%0d", e_color_state, level_done, jump_ready);
    color_model = '0;
    pos_model   = 28'h1;

    // Asynchronous reset in the middle of a move
    do_jump(3'd4, 1'b0, 1);
    jump_valid = 1'b1; e_jump_qb = 3'd3;
    @(negedge clk);
    jump_valid = 1'b0; e_jump_qb = 3'd0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("areset_position", position_qb, 28'h1);
    chk("areset_next", e_next_qb, 28'h1);
    chk("areset_color", e_color_state, 0);
    chk("areset_done", done_move, 0);
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    k = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done_move === 1'b1) dones++;
      if (falling === 1'b1) k++;
    end
    chk("areset_no_done", dones, 0);
    chk("areset_no_fall", k, 0);
    chk("areset_ready", jump_ready, 1);
    $display("async reset mid-move: pos=%h color=%h dones=%0d", position_qb, e_color_state, dones);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
